// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control FSM: one-hot state encoding,
// the invalid header address and the default wait-timeout length.
package router_pkg;

    typedef enum logic [7:0] {
        DECODE_ADDRESS     = 8'b0000_0001,
        LOAD_FIRST_DATA    = 8'b0000_0010,
        LOAD_DATA          = 8'b0000_0100,
        LOAD_PARITY        = 8'b0000_1000,
        FIFO_FULL_STATE    = 8'b0001_0000,
        LOAD_AFTER_FULL    = 8'b0010_0000,
        CHECK_PARITY_ERROR = 8'b0100_0000,
        WAIT_TILL_EMPTY    = 8'b1000_0000
    } state_t;

    localparam logic [1:0] ADDR_INVALID    = 2'd3;
    localparam int         TIMEOUT_DEFAULT = 1024;

    // Pick one of the three per-port flags by destination address; the
    // invalid address selects nothing.
    function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
        logic sel;
        sel = 1'b0;
        case (addr)
            2'd0:    sel = flags[0];
            2'd1:    sel = flags[1];
            2'd2:    sel = flags[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between the router input side / register block / FIFO synchronizer
// (master) and the router control FSM (slave).
interface router_fsm_if;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic [1:0] addr_q;
    logic       timeout_drop;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  rst_int_reg, write_enb_reg, busy, addr_q, timeout_drop
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output rst_int_reg, write_enb_reg, busy, addr_q, timeout_drop
    );

endinterface

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY state: cleared while idle, counts while
// enabled, and flags expiry on the last allowed waiting cycle.
module router_wait_timer #(
    parameter int LIMIT = 1024,
    parameter int W     = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] count_reg;

    assign expire = (count_reg == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: sequences header/data/parity loading and FIFO writes.
// Optional wait timeout enabled by defining ROUTER_FSM_TIMEOUT_EN.
import router_pkg::*;

module router_fsm #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TMR_W          = 10
) (
    input logic         clk,
    input logic         reset,
    router_fsm_if.slave bus
);

    state_t     state_reg, state_next;
    logic [1:0] addr_q_reg, addr_q_next;
    logic       timeout_drop_reg, timeout_drop_next;
    logic       timer_expire;

    logic [2:0] empty_vec;
    logic [2:0] soft_vec;
    logic       hdr_empty;
    logic       sel_empty;
    logic       sel_soft;

    assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign hdr_empty = port_sel(empty_vec, bus.data_in);
    assign sel_empty = port_sel(empty_vec, addr_q_reg);
    assign sel_soft  = port_sel(soft_vec, addr_q_reg);

`ifdef ROUTER_FSM_TIMEOUT_EN
    // Timer runs only while waiting, so it restarts from zero on every WTE entry.
    router_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TMR_W)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_reg != WAIT_TILL_EMPTY),
        .en     (state_reg == WAIT_TILL_EMPTY),
        .expire (timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= DECODE_ADDRESS;
            addr_q_reg       <= 2'd0;
            timeout_drop_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_q_reg       <= addr_q_next;
            timeout_drop_reg <= timeout_drop_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        addr_q_next       = addr_q_reg;
        timeout_drop_next = 1'b0;

        case (state_reg)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && (bus.data_in != ADDR_INVALID)) begin
                    addr_q_next = bus.data_in;
                    state_next  = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)           state_next = DECODE_ADDRESS;
                else if (bus.low_packet_valid) state_next = LOAD_PARITY;
                else                           state_next = LOAD_DATA;
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                // An emptied FIFO on the expiry cycle still gets the packet.
                if (sel_empty) begin
                    state_next = LOAD_FIRST_DATA;
                end else if (timer_expire) begin
                    state_next        = DECODE_ADDRESS;
                    timeout_drop_next = 1'b1;
                end
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        // Read-timeout soft reset of the selected port aborts the packet from anywhere.
        if ((state_reg != DECODE_ADDRESS) && sel_soft) begin
            state_next        = DECODE_ADDRESS;
            timeout_drop_next = 1'b0;
        end
    end

    assign bus.detect_add    = (state_reg == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_reg == LOAD_DATA);
    assign bus.laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_reg == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY) ||
                               (state_reg == LOAD_AFTER_FULL);
    assign bus.busy          = (state_reg != DECODE_ADDRESS) && (state_reg != LOAD_DATA);
    assign bus.addr_q        = addr_q_reg;
    assign bus.timeout_drop  = timeout_drop_reg;

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; the timeout scenario runs only
// when ROUTER_FSM_TIMEOUT_EN is defined.
module tb_router_fsm;

    // Output vector: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0010;
    localparam logic [7:0] E_LAF = 8'b0001_0011;
    localparam logic [7:0] E_FFS = 8'b0000_1001;
    localparam logic [7:0] E_CPE = 8'b0000_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   wenb_cycles;

    router_fsm_if bus ();

`ifdef ROUTER_FSM_TIMEOUT_EN
    router_fsm #(.TIMEOUT_CYCLES(8), .TMR_W(3)) dut (
`else
    router_fsm dut (
`endif
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
            $display("check %-22s observed=%02h expected=%02h ok", tag, observed, expected);
        end else begin
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        wenb_cycles = 0;
        reset  = 1'b1;
        bus.pkt_valid = 1'b0;        bus.data_in = 2'd0;
        bus.fifo_full = 1'b0;
        bus.fifo_empty_0 = 1'b1;     bus.fifo_empty_1 = 1'b1;  bus.fifo_empty_2 = 1'b1;
        bus.soft_reset_0 = 1'b0;     bus.soft_reset_1 = 1'b0;  bus.soft_reset_2 = 1'b0;
        bus.parity_done = 1'b0;      bus.low_packet_valid = 1'b0;

        step();
        chk("reset_state", obs_vec(), E_DA);
        chk("reset_addr_q", {6'd0, bus.addr_q}, 8'd0);
        chk("reset_drop", {7'd0, bus.timeout_drop}, 8'd0);
        reset = 1'b0;

        // Reset in the middle of LOAD_DATA
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        step(); chk("t1_lfd", obs_vec(), E_LFD);
        step(); chk("t1_ld", obs_vec(), E_LD);
        reset = 1'b1;
        step(); chk("t1_reset_da", obs_vec(), E_DA);
        reset = 1'b0;
        bus.pkt_valid = 1'b0;
        step(); chk("t1_idle_da", obs_vec(), E_DA);

        // Header addr 1 into an empty FIFO, 3 payload bytes, parity
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        step(); chk("t2_lfd", obs_vec(), E_LFD);
        chk("t2_addr_q", {6'd0, bus.addr_q}, 8'd1);
        bus.data_in = 2'd3;
        step(); chk("t2_ld1", obs_vec(), E_LD);   wenb_cycles += int'(bus.write_enb_reg);
        step(); chk("t2_ld2", obs_vec(), E_LD);   wenb_cycles += int'(bus.write_enb_reg);
        step(); chk("t2_ld3", obs_vec(), E_LD);   wenb_cycles += int'(bus.write_enb_reg);
        bus.pkt_valid = 1'b0;
        step(); chk("t2_lp", obs_vec(), E_LP);    wenb_cycles += int'(bus.write_enb_reg);
        step(); chk("t2_cpe", obs_vec(), E_CPE);  wenb_cycles += int'(bus.write_enb_reg);
        step(); chk("t2_da", obs_vec(), E_DA);    wenb_cycles += int'(bus.write_enb_reg);
        chk("t2_wenb_cycles", 8'(wenb_cycles), 8'd4);
        chk("t2_addr_hold", {6'd0, bus.addr_q}, 8'd1);

        // Invalid header address keeps the FSM in decode
        bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
        step(); chk("inv_addr_da", obs_vec(), E_DA);

        // fifo_full for 3 cycles during LOAD_DATA
        bus.data_in = 2'd0;
        step(); chk("t3_lfd", obs_vec(), E_LFD);
        step(); chk("t3_ld", obs_vec(), E_LD);
        bus.fifo_full = 1'b1;
        step(); chk("t3_ffs1", obs_vec(), E_FFS);
        step(); chk("t3_ffs2", obs_vec(), E_FFS);
        step(); chk("t3_ffs3", obs_vec(), E_FFS);
        bus.fifo_full = 1'b0;
        step(); chk("t3_laf", obs_vec(), E_LAF);
        step(); chk("t3_ld_again", obs_vec(), E_LD);
        bus.pkt_valid = 1'b0;
        step(); chk("t3_lp", obs_vec(), E_LP);
        bus.fifo_full = 1'b1;
        step(); chk("t3_cpe", obs_vec(), E_CPE);
        step(); chk("t3_cpe_full_ffs", obs_vec(), E_FFS);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
        step(); chk("t3_laf2", obs_vec(), E_LAF);
        step(); chk("t3_laf_done_da", obs_vec(), E_DA);
        bus.parity_done = 1'b0;

        // Header addr 2 waits on a non-empty FIFO for 5 cycles
        bus.fifo_empty_2 = 1'b0;
        bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step(); chk($sformatf("t4_wte%0d", i + 1), obs_vec(), E_WTE);
        end
        chk("t4_addr_q", {6'd0, bus.addr_q}, 8'd2);
        bus.fifo_empty_2 = 1'b1;
        step(); chk("t4_lfd", obs_vec(), E_LFD);
        bus.pkt_valid = 1'b0;
        step(); chk("t4_ld", obs_vec(), E_LD);
        step(); chk("t4_lp", obs_vec(), E_LP);
        step(); chk("t4_cpe", obs_vec(), E_CPE);
        step(); chk("t4_da", obs_vec(), E_DA);

        // Soft reset: only the selected port's soft reset acts
        bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
        step(); chk("t5_lfd", obs_vec(), E_LFD);
        step(); chk("t5_ld", obs_vec(), E_LD);
        bus.soft_reset_2 = 1'b1;
        step(); chk("t5_sr2_ignored", obs_vec(), E_LD);
        bus.soft_reset_2 = 1'b0; bus.soft_reset_0 = 1'b1;
        step(); chk("t5_sr0_da", obs_vec(), E_DA);
        bus.soft_reset_0 = 1'b0; bus.pkt_valid = 1'b0;
        step(); chk("t5_da_hold", obs_vec(), E_DA);

`ifdef ROUTER_FSM_TIMEOUT_EN
        // FIFO never empties: 8 cycles of waiting, then a drop pulse
        bus.fifo_empty_1 = 1'b0;
        bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
        for (int i = 0; i < 8; i++) begin
            step(); chk($sformatf("t6_wte%0d", i + 1), obs_vec(), E_WTE);
            chk($sformatf("t6_nodrop%0d", i + 1), {7'd0, bus.timeout_drop}, 8'd0);
            bus.pkt_valid = 1'b0;
        end
        step(); chk("t6_da", obs_vec(), E_DA);
        chk("t6_drop_pulse", {7'd0, bus.timeout_drop}, 8'd1);
        step(); chk("t6_drop_clear", {7'd0, bus.timeout_drop}, 8'd0);
        bus.fifo_empty_1 = 1'b1;
`else
        chk("drop_tied_low", {7'd0, bus.timeout_drop}, 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
